// File: rtl/fifo_pkg.sv
// Shared sizing, threshold defaults and helper types for the 8-entry transaction FIFO.
package fifo_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam int unsigned AF_THR = 6;
  localparam int unsigned AE_THR = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, read data registered on rd_e, no reset on storage.
module fifo_mem
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  wr_e,
  input  logic  rd_e,
  input  ptr_t  wr_ptr,
  input  ptr_t  rd_ptr,
  input  data_t data_w,
  output data_t data_r
);

  data_t mem_q [DEPTH];
  data_t data_r_q;

  // A read and write to the same slot in one cycle returns the old word (full + push/pop).
  always_ff @(posedge clk) begin
    if (wr_e) begin
      mem_q[wr_ptr] <= data_w;
    end
    if (rd_e) begin
      data_r_q <= mem_q[rd_ptr];
    end
  end

  assign data_r = data_r_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointer/count sequencing, sticky error, registered read strobe and status flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned AfThr = AF_THR,
  parameter int unsigned AeThr = AE_THR
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  logic  error_q, error_d;
  logic  valid_q, valid_d;
  logic  data_live_q, data_live_d;
  logic  push_acc, pop_acc;
  data_t mem_rdata;

  always_comb begin
    pop_acc     = pop && (count_q != '0);
    push_acc    = push && ((count_q != cnt_t'(DEPTH)) || pop_acc);
    wr_ptr_d    = push_acc ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d    = pop_acc ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    count_d     = count_q + cnt_t'(push_acc) - cnt_t'(pop_acc);
    error_d     = error_q | (push && !push_acc) | (pop && !pop_acc);
    valid_d     = pop_acc;
    data_live_d = data_live_q | pop_acc;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_live_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      error_q     <= error_d;
      valid_q     <= valid_d;
      data_live_q <= data_live_d;
    end
  end

  fifo_mem u_mem (
    .clk    (clk),
    .wr_e   (push_acc),
    .rd_e   (pop_acc),
    .wr_ptr (wr_ptr_q),
    .rd_ptr (rd_ptr_q),
    .data_w (data_in),
    .data_r (mem_rdata)
  );

  // The memory read register has no reset; mask it until the first pop after reset.
  assign data_out     = data_live_q ? mem_rdata : '0;
  assign valid_out    = valid_q;
  assign count        = count_q;
  assign error        = error_q;
  assign full         = (count_q == cnt_t'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= cnt_t'(AfThr));
  assign almost_empty = (count_q <= cnt_t'(AeThr));

endmodule
